lifo_arbiter: RTL and testbench
===============================

// Module: lifo_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-clock FWFT LIFO ("stack") between CLIENTS requesters.
//  Each requester presents a push or pop; at most one operation is issued to the LIFO per cycle.
//  Push and pop are never issued together, so the LIFO's simultaneous write/read case is never exercised.
//  Pop data returns to the winning requester one cycle later. Sits between client logic and a lifo instance.
// PARAMETERS
//  CLIENTS    4                        number of requesters, >=2
//  CLIENTS_W  $clog2(CLIENTS)          grant index width
//  DATA_W     32                       data width, equals attached LIFO DATA_W
//  ERR_CNT_W  16                       width of pop-on-empty error counter
// PORTS
//  clk          in   1                 clock; all state on posedge
//  rst          in   1                 synchronous active-high reset
//  req          in   CLIENTS           per-client request, held until ack
//  op           in   CLIENTS           per-client op: 0=push, 1=pop; stable while req high
//  wdata        in   CLIENTS*DATA_W    per-client push data, packed [CLIENTS-1:0][DATA_W-1:0]
//  ack          out  CLIENTS           one-hot, combinational: request accepted this cycle
//  gnt_id       out  CLIENTS_W         registered index of last granted client
//  rsp_valid    out  CLIENTS           one-hot pulse, registered: pop result for that client
//  rsp_data     out  DATA_W            registered pop data, held until next pop completes
//  rsp_err      out  1                 registered: last pop hit an empty LIFO
//  err_cnt      out  ERR_CNT_W         saturating count of pops on empty
//  lifo_w_req   out  1                 to LIFO w_req
//  lifo_w_data  out  DATA_W            to LIFO w_data
//  lifo_r_req   out  1                 to LIFO r_req
//  lifo_r_data  in   DATA_W            from LIFO r_data (FWFT, top of stack)
//  lifo_empty   in   1                 from LIFO empty
//  lifo_full    in   1                 from LIFO full
// BEHAVIOUR
//  Reset: ptr=CLIENTS-1 (client 0 wins first). gnt_id=CLIENTS-1. rsp_valid=0, rsp_data=0, rsp_err=0, err_cnt=0.
//   While rst=1: ack, lifo_w_req and lifo_r_req forced to 0.
//  Eligibility: elig[i] = req[i] & (op[i] | ~lifo_full). Push on full stalls (no ack). Pop is always eligible.
//  Arbitration (combinational): winner = first elig index searching ptr+1, ptr+2, ... mod CLIENTS.
//   No elig: no ack, no LIFO op, ptr unchanged.
//  On winner w: ack[w]=1; ptr<=w; gnt_id<=w.
//   Push: lifo_w_req=1, lifo_w_data=wdata[w]. Completes at ack; no response.
//   Pop & ~lifo_empty: lifo_r_req=1. Next cycle: rsp_data=lifo_r_data sampled at grant; rsp_err=0.
//   Pop & lifo_empty: no LIFO op. Next cycle: rsp_data=0, rsp_err=1; err_cnt+1, saturating at all-ones.
//   Either pop: rsp_valid=(1<<w) for exactly one cycle.
//  lifo_w_data=0 when not pushing. lifo_w_req and lifo_r_req are never both 1.
//  Latency: push 0 cycles (ack = issue). Pop data 1 cycle after ack.
//   One op per cycle, back-to-back allowed. Pop after push in consecutive cycles returns the pushed word.
//  Full: only pops are granted. A pop frees space, so a stalled push can win the following cycle.
//  Empty: pops complete with error and do not disturb LIFO state.
//  Fairness: a continuously eligible client is granted within CLIENTS cycles.
//  Reset mid-operation: a pending rsp_valid is dropped. LIFO shares rst and is cleared at the same time.
//  Requesters must keep req/op/wdata stable until ack. Dropping req before ack is allowed and cancels the request.
// STRUCTURE
//  Package lifo_arb_pkg: typedef enum logic {OP_PUSH=1'b0, OP_POP=1'b1} lifo_op_e.
//  Sub-module rr_pick: combinational round-robin picker.
//   Inputs: elig[CLIENTS], ptr. Outputs: one-hot gnt, index, any.
//   Implemented by rotate, priority-encode, un-rotate.
//  Top level holds ptr, the response registers, err_cnt and the LIFO-side muxing.
// TESTING
//  1 Reset; client2 push 0xA5 -> same cycle ack=4'b0100, lifo_w_req=1, lifo_w_data=0xA5. No rsp_valid next cycle.
//  2 All 4 clients push continuously, LIFO not full -> ack sequence 0,1,2,3,0. Never two acks in one cycle.
//  3 Push 0x11 then 0x22; client1 pops -> next cycle rsp_valid=4'b0010, rsp_data=0x22, rsp_err=0.
//  4 LIFO empty; client3 pops -> ack[3], lifo_r_req=0. Next cycle rsp_valid=4'b1000, rsp_data=0, rsp_err=1, err_cnt=1.
//  5 lifo_full=1; client0 push, client1 pop -> ack[1] only. Client0 acked the cycle after lifo_full drops.
//  6 rst pulsed the cycle after a pop ack -> rsp_valid stays 0, err_cnt=0. Next request from clients 0 and 3 -> ack[0].

Source files
------------

// File: rtl/lifo_arb_pkg.sv
// Shared types for the LIFO arbiter: the per-client operation encoding.
package lifo_arb_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } lifo_op_e;

endpackage

// File: rtl/lifo_arb_if.sv
// Client-side bundle of the LIFO arbiter: per-client requests plus the shared pop response.
interface lifo_arb_if #(
    parameter int CLIENTS = 4,
    parameter int DATA_W  = 32
);
    logic [CLIENTS-1:0]             req;
    logic [CLIENTS-1:0]             op;
    logic [CLIENTS-1:0][DATA_W-1:0] wdata;
    logic [CLIENTS-1:0]             ack;
    logic [CLIENTS-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_data;
    logic                           rsp_err;

    modport master (
        output req, op, wdata,
        input  ack, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req, op, wdata,
        output ack, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/lifo_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible index after ptr wins.
// Works by rotating elig so ptr+1 lands at bit 0, priority-encoding, then un-rotating.
module rr_pick #(
    parameter int CLIENTS   = 4,
    parameter int CLIENTS_W = $clog2(CLIENTS)
) (
    input  logic [CLIENTS-1:0]   elig,
    input  logic [CLIENTS_W-1:0] ptr,
    output logic [CLIENTS-1:0]   gnt,
    output logic [CLIENTS_W-1:0] index,
    output logic                 any
);
    logic [2*CLIENTS-1:0] dbl;
    logic [CLIENTS-1:0]   rot;
    int                   start;
    int                   off;
    int                   pos;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        start = (int'(ptr) + 1) % CLIENTS;
        dbl   = {elig, elig};
        rot   = CLIENTS'(dbl >> start);
        off   = 0;
        any   = 1'b0;
        // Descending scan leaves the lowest set bit, i.e. nearest to ptr+1.
        for (int k = CLIENTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
                any = 1'b1;
            end
        end
        pos   = (start + off) % CLIENTS;
        gnt   = any ? (CLIENTS'(1) << pos) : '0;
        index = CLIENTS_W'(pos);
    end
endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one FWFT LIFO between several clients; at most one
// push or pop is issued per cycle and pop results return one cycle after ack.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int CLIENTS   = 4,
    parameter int CLIENTS_W = $clog2(CLIENTS),
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lifo_arb_if.slave            cli,
    output logic [CLIENTS_W-1:0] gnt_id,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 lifo_w_req,
    output logic [DATA_W-1:0]    lifo_w_data,
    output logic                 lifo_r_req,
    input  logic [DATA_W-1:0]    lifo_r_data,
    input  logic                 lifo_empty,
    input  logic                 lifo_full
);
    localparam logic [CLIENTS_W-1:0] PTR_RST = CLIENTS_W'(CLIENTS - 1);

    logic [CLIENTS_W-1:0] ptr;
    logic [CLIENTS-1:0]   elig;
    logic [CLIENTS-1:0]   win_gnt;
    logic [CLIENTS_W-1:0] win_idx;
    logic                 win_any;
    lifo_op_e             win_op;
    logic                 grant;

    // Pops never stall; a push waits while the LIFO is full.
    assign elig = cli.req & (cli.op | {CLIENTS{~lifo_full}});

    rr_pick #(
        .CLIENTS   (CLIENTS),
        .CLIENTS_W (CLIENTS_W)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .gnt   (win_gnt),
        .index (win_idx),
        .any   (win_any)
    );

    assign win_op = lifo_op_e'(cli.op[win_idx]);
    assign grant  = win_any & ~rst;
    assign gnt_id = ptr;

    always_comb begin
        cli.ack     = '0;
        lifo_w_req  = 1'b0;
        lifo_w_data = '0;
        lifo_r_req  = 1'b0;
        if (grant) begin
            cli.ack = win_gnt;
            if (win_op == OP_PUSH) begin
                lifo_w_req  = 1'b1;
                lifo_w_data = cli.wdata[win_idx];
            end else if (!lifo_empty) begin
                lifo_r_req = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= PTR_RST;
            cli.rsp_valid <= '0;
            cli.rsp_data  <= '0;
            cli.rsp_err   <= 1'b0;
            err_cnt       <= '0;
        end else begin
            cli.rsp_valid <= '0;
            if (grant) begin
                ptr <= win_idx;
                if (win_op == OP_POP) begin
                    cli.rsp_valid <= win_gnt;
                    cli.rsp_err   <= lifo_empty;
                    cli.rsp_data  <= lifo_empty ? '0 : lifo_r_data;
                    if (lifo_empty && err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based LIFO and round-robin reference model.
module tb_lifo_arbiter;
    import lifo_arb_pkg::*;

    localparam int CLIENTS = 4;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        gnt_id;
    logic [15:0]       err_cnt;
    logic              lifo_w_req;
    logic [31:0]       lifo_w_data;
    logic              lifo_r_req;
    logic [31:0]       rdata_r;
    logic              empty_r;
    logic              full_r;

    int total = 0;
    int bad   = 0;

    lifo_arb_if #(.CLIENTS(CLIENTS), .DATA_W(DATA_W)) bus ();

    lifo_arbiter #(.CLIENTS(CLIENTS), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cli         (bus),
        .gnt_id      (gnt_id),
        .err_cnt     (err_cnt),
        .lifo_w_req  (lifo_w_req),
        .lifo_w_data (lifo_w_data),
        .lifo_r_req  (lifo_r_req),
        .lifo_r_data (rdata_r),
        .lifo_empty  (empty_r),
        .lifo_full   (full_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  op;
        logic        full;
        logic        empty;
        logic [3:0]  exp_ack;
        logic        exp_wreq;
        logic [31:0] exp_wdata;
        logic        exp_rreq;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_gnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req   = '0;
        bus.op    = '0;
        bus.wdata = '0;
        full_r    = 1'b0;
        empty_r   = 1'b1;
        rdata_r   = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference-model state for the randomized phase.
    logic [31:0] stk[$];
    logic [31:0] data_m[CLIENTS];
    logic        pend[CLIENTS];
    logic        popm[CLIENTS];
    int          wait_cnt[CLIENTS];

    initial begin
        rst = 1'b1;
        idle_inputs();

        //            req     op      full  empty ack     wreq wdata          rreq valid   data          err  gnt
        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 2'd3};
        vecs[1] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 32'h100,       1'b0, 4'b0000, 32'h0,         1'b0, 2'd0};
        vecs[2] = '{4'b1010, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 2'd3};
        vecs[3] = '{4'b1010, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 32'h0,         1'b1, 4'b1000, 32'h55,        1'b0, 2'd3};
        vecs[4] = '{4'b0110, 4'b0100, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h101,       1'b0, 4'b0000, 32'h0,         1'b0, 2'd1};
        vecs[5] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h0,         1'b0, 4'b0100, 32'h0,         1'b1, 2'd2};
        vecs[6] = '{4'b1100, 4'b1100, 1'b1, 1'b0, 4'b0100, 1'b0, 32'h0,         1'b1, 4'b0100, 32'h55,        1'b0, 2'd2};

        // Reset state
        do_reset();
        check("rst_gnt_id", 64'(gnt_id), 64'd3);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);

        // Vector table: each entry starts from reset, so the search begins at client 0.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            bus.req = vecs[v].req;
            bus.op  = vecs[v].op;
            for (int i = 0; i < CLIENTS; i++) bus.wdata[i] = 32'h100 + 32'(i);
            full_r  = vecs[v].full;
            empty_r = vecs[v].empty;
            rdata_r = vecs[v].empty ? 32'hDEAD_BEEF : 32'h55;
            #2;
            check($sformatf("vec%0d_ack", v), 64'(bus.ack), 64'(vecs[v].exp_ack));
            check($sformatf("vec%0d_wreq", v), 64'(lifo_w_req), 64'(vecs[v].exp_wreq));
            check($sformatf("vec%0d_wdata", v), 64'(lifo_w_data), 64'(vecs[v].exp_wdata));
            check($sformatf("vec%0d_rreq", v), 64'(lifo_r_req), 64'(vecs[v].exp_rreq));
            tick();
            idle_inputs();
            check($sformatf("vec%0d_valid", v), 64'(bus.rsp_valid), 64'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v), 64'(bus.rsp_data), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d_err", v), 64'(bus.rsp_err), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_gnt", v), 64'(gnt_id), 64'(vecs[v].exp_gnt));
        end

        // Client 2 push, same-cycle issue, no response afterwards
        do_reset();
        bus.req = 4'b0100; bus.op = 4'b0000; bus.wdata[2] = 32'hA5;
        #2;
        check("t1_ack", 64'(bus.ack), 64'b0100);
        check("t1_wreq", 64'(lifo_w_req), 64'd1);
        check("t1_wdata", 64'(lifo_w_data), 64'hA5);
        check("t1_rreq", 64'(lifo_r_req), 64'd0);
        tick();
        bus.req = '0;
        check("t1_no_rsp", 64'(bus.rsp_valid), 64'd0);
        check("t1_gnt", 64'(gnt_id), 64'd2);

        // All clients pushing: grants rotate 0,1,2,3,0
        do_reset();
        bus.req = 4'b1111; bus.op = 4'b0000;
        for (int i = 0; i < CLIENTS; i++) bus.wdata[i] = 32'h200 + 32'(i);
        for (int k = 0; k < 5; k++) begin
            #2;
            check($sformatf("t2_ack%0d", k), 64'(bus.ack), 64'(4'b0001 << (k % 4)));
            check($sformatf("t2_wdata%0d", k), 64'(lifo_w_data), 64'(32'h200 + 32'(k % 4)));
            tick();
        end
        bus.req = '0;

        // Push 0x11, push 0x22, then client 1 pops the top word
        do_reset();
        bus.req = 4'b0001; bus.op = 4'b0000; bus.wdata[0] = 32'h11;
        #2 check("t3_push1", 64'(lifo_w_data), 64'h11);
        tick();
        empty_r = 1'b0; rdata_r = 32'h11; bus.wdata[0] = 32'h22;
        #2 check("t3_push2", 64'(lifo_w_data), 64'h22);
        tick();
        rdata_r = 32'h22;
        bus.req = 4'b0010; bus.op = 4'b0010;
        #2;
        check("t3_ack", 64'(bus.ack), 64'b0010);
        check("t3_rreq", 64'(lifo_r_req), 64'd1);
        check("t3_wreq", 64'(lifo_w_req), 64'd0);
        tick();
        bus.req = '0;
        check("t3_valid", 64'(bus.rsp_valid), 64'b0010);
        check("t3_data", 64'(bus.rsp_data), 64'h22);
        check("t3_err", 64'(bus.rsp_err), 64'd0);
        tick();
        check("t3_pulse", 64'(bus.rsp_valid), 64'd0);
        check("t3_hold", 64'(bus.rsp_data), 64'h22);

        // Pop on empty LIFO from client 3
        do_reset();
        bus.req = 4'b1000; bus.op = 4'b1000;
        #2;
        check("t4_ack", 64'(bus.ack), 64'b1000);
        check("t4_rreq", 64'(lifo_r_req), 64'd0);
        tick();
        bus.req = '0;
        check("t4_valid", 64'(bus.rsp_valid), 64'b1000);
        check("t4_data", 64'(bus.rsp_data), 64'd0);
        check("t4_err", 64'(bus.rsp_err), 64'd1);
        check("t4_cnt", 64'(err_cnt), 64'd1);

        // Full LIFO: pop wins, push stalls until full drops
        do_reset();
        full_r = 1'b1; empty_r = 1'b0; rdata_r = 32'h77;
        bus.req = 4'b0011; bus.op = 4'b0010; bus.wdata[0] = 32'h33;
        #2;
        check("t5_ack_pop", 64'(bus.ack), 64'b0010);
        check("t5_wreq_full", 64'(lifo_w_req), 64'd0);
        tick();
        bus.req = 4'b0001;
        #2 check("t5_stall", 64'(bus.ack), 64'd0);
        tick();
        full_r = 1'b0;
        #2;
        check("t5_ack_push", 64'(bus.ack), 64'b0001);
        check("t5_wdata", 64'(lifo_w_data), 64'h33);
        tick();
        bus.req = '0;

        // Reset sampled at the edge ending a pop-ack cycle drops the response
        do_reset();
        bus.req = 4'b0100; bus.op = 4'b0100;
        #2 check("t6_ack", 64'(bus.ack), 64'b0100);
        rst = 1'b1;
        #1 check("t6_ack_in_rst", 64'(bus.ack), 64'd0);
        tick();
        rst = 1'b0;
        bus.req = '0;
        check("t6_valid", 64'(bus.rsp_valid), 64'd0);
        check("t6_cnt", 64'(err_cnt), 64'd0);
        check("t6_err", 64'(bus.rsp_err), 64'd0);
        bus.req = 4'b1001; bus.op = 4'b0000;
        #2 check("t6_next", 64'(bus.ack), 64'b0001);
        tick();
        bus.req = '0;

        // Randomized traffic against the reference model
        do_reset();
        begin
            int          last = CLIENTS - 1;
            int          w;
            logic [3:0]  exp_valid;
            logic [31:0] exp_data = '0;
            logic        exp_err  = 1'b0;
            int          exp_cnt  = 0;
            logic        full_m;
            logic        elig_m[CLIENTS];
            stk.delete();
            for (int i = 0; i < CLIENTS; i++) begin
                pend[i] = 1'b0; popm[i] = 1'b0; data_m[i] = '0; wait_cnt[i] = 0;
            end
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int i = 0; i < CLIENTS; i++) begin
                    if (!pend[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            pend[i]   = 1'b1;
                            popm[i]   = ($urandom_range(0, 2) == 0);
                            data_m[i] = $urandom;
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        pend[i] = 1'b0;
                    end
                    bus.req[i]   = pend[i];
                    bus.op[i]    = popm[i];
                    bus.wdata[i] = data_m[i];
                end
                full_m  = (stk.size() == DEPTH);
                full_r  = full_m;
                empty_r = (stk.size() == 0);
                rdata_r = empty_r ? 32'hDEAD_BEEF : stk[$];

                w = -1;
                for (int i = 0; i < CLIENTS; i++) elig_m[i] = pend[i] && (popm[i] || !full_m);
                for (int k = 1; k <= CLIENTS; k++) begin
                    if (w < 0 && elig_m[(last + k) % CLIENTS]) w = (last + k) % CLIENTS;
                end

                #2;
                check("rnd_ack", 64'(bus.ack), (w >= 0) ? 64'(4'b0001 << w) : 64'd0);
                check("rnd_wreq", 64'(lifo_w_req), 64'(w >= 0 && !popm[w]));
                check("rnd_wdata", 64'(lifo_w_data), (w >= 0 && !popm[w]) ? 64'(data_m[w]) : 64'd0);
                check("rnd_rreq", 64'(lifo_r_req), 64'(w >= 0 && popm[w] && stk.size() != 0));

                for (int i = 0; i < CLIENTS; i++) begin
                    if (i == w) begin
                        check("rnd_fair", 64'(wait_cnt[i] < CLIENTS), 64'd1);
                        wait_cnt[i] = 0;
                    end else if (elig_m[i]) begin
                        wait_cnt[i]++;
                    end else begin
                        wait_cnt[i] = 0;
                    end
                end

                exp_valid = '0;
                if (w >= 0) begin
                    last = w;
                    if (popm[w]) begin
                        exp_valid = 4'b0001 << w;
                        if (stk.size() == 0) begin
                            exp_data = '0;
                            exp_err  = 1'b1;
                            if (exp_cnt < 65535) exp_cnt++;
                        end else begin
                            exp_data = stk.pop_back();
                            exp_err  = 1'b0;
                        end
                    end else begin
                        stk.push_back(data_m[w]);
                    end
                    pend[w] = 1'b0;
                end

                tick();
                check("rnd_valid", 64'(bus.rsp_valid), 64'(exp_valid));
                check("rnd_data", 64'(bus.rsp_data), 64'(exp_data));
                check("rnd_err", 64'(bus.rsp_err), 64'(exp_err));
                check("rnd_cnt", 64'(err_cnt), 64'(exp_cnt));
                check("rnd_gnt", 64'(gnt_id), 64'(last));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
